// File: rtl/sprite_pkg.sv
// Shared constants, attribute field layout and FSM encoding for the sprite line fetcher.
package sprite_pkg;

    localparam int NUM_SPRITES = 8;
    localparam int SPRITE_DIM  = 16;
    localparam int IDX_W       = 3;
    localparam int ATTR_W      = 24;

    localparam int ATTR_EN_BIT    = 23;
    localparam int ATTR_VFLIP_BIT = 22;
    localparam int ATTR_HFLIP_BIT = 21;
    localparam int ATTR_RSVD_BIT  = 20;
    localparam int ATTR_PAT_LSB   = 16;
    localparam int ATTR_Y_LSB     = 8;
    localparam int ATTR_X_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/sprite_attr_table.sv
// 8 x 24-bit sprite attribute registers: synchronous write, combinational read.
// Flip bits are only kept when SPRITE_FLIP_EN is defined.
module sprite_attr_table
    import sprite_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wen,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [ATTR_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [ATTR_W-1:0] o_rdata
);

`ifdef SPRITE_FLIP_EN
    localparam logic [ATTR_W-1:0] WMASK = '1;
`else
    localparam logic [ATTR_W-1:0] WMASK = ~((ATTR_W'(1) << ATTR_VFLIP_BIT) |
                                            (ATTR_W'(1) << ATTR_HFLIP_BIT));
`endif

    logic [NUM_SPRITES-1:0][ATTR_W-1:0] r_attr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_attr <= '0;
        end else if (i_wen) begin
            r_attr[i_waddr] <= i_wdata & WMASK;
        end
    end

    assign o_rdata = r_attr[i_raddr];

endmodule

// File: rtl/sprite_line_fetcher.sv
// Builds one scanline of sprite pixels: scans sprites 7..0, fetches 16 pixels per hit.
// Optional SPRITE_FLIP_EN enables horizontal/vertical flip of the fetched row.
module sprite_line_fetcher
    import sprite_pkg::*;
#(
    parameter logic [3:0] TRANSPARENT_IDX = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  next_y,
    input  logic        attr_wen,
    input  logic [2:0]  attr_addr,
    input  logic [23:0] attr_wdata,
    output logic        mem_ren,
    output logic [11:0] mem_raddr,
    input  logic [5:0]  mem_rdata,
    output logic        lb_wen,
    output logic [7:0]  lb_waddr,
    output logic [3:0]  lb_wdata,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    fetch_state_t r_state, w_next;

    logic [2:0]  r_idx;
    logic [7:0]  r_y;
    logic [4:0]  r_cnt;
    logic [7:0]  r_x;
    logic [3:0]  r_pat;
    logic [3:0]  r_row;
    logic [3:0]  r_wcol;
    logic        r_wr_pend;

    logic [23:0] w_attr;
    logic [7:0]  w_diff;
    logic        w_hit;
    logic        w_abort;
    logic        w_last_col;
    logic        w_last_idx;
    logic [3:0]  w_rowp;
    logic [3:0]  w_colp;
    logic [8:0]  w_sum;
    logic        w_unused_bits;

    sprite_attr_table u_attr (
        .clk     (clk),
        .reset   (reset),
        .i_wen   (attr_wen),
        .i_waddr (attr_addr),
        .i_wdata (attr_wdata),
        .i_raddr (r_idx),
        .o_rdata (w_attr)
    );

    // Row within the sprite wraps mod 256 so sprites straddling y=255 still hit.
    assign w_diff     = r_y - w_attr[ATTR_Y_LSB +: 8];
    assign w_hit      = w_attr[ATTR_EN_BIT] && (w_diff[7:4] == 4'd0);
    assign w_abort    = line_start && (r_state != ST_IDLE);
    assign w_last_col = (r_cnt == 5'd16);
    assign w_last_idx = (r_idx == 3'd0);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        busy    = (r_state != ST_IDLE);
        done    = 1'b0;
        overrun = w_abort;
        mem_ren = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (line_start) w_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_hit)           w_next = ST_FETCH;
                else if (w_last_idx) w_next = ST_DONE;
            end
            ST_FETCH: begin
                mem_ren = !r_cnt[4];
                if (w_last_col) w_next = w_last_idx ? ST_DONE : ST_SCAN;
            end
            ST_DONE: begin
                done   = !line_start;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_abort) w_next = ST_SCAN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_x       <= '0;
            r_pat     <= '0;
            r_row     <= '0;
            r_wcol    <= '0;
            r_wr_pend <= 1'b0;
        end else begin
            // An abort drops the write that would carry the last outstanding read.
            r_wr_pend <= mem_ren && !w_abort;
            r_wcol    <= r_cnt[3:0];
            if (line_start) begin
                r_y   <= next_y;
                r_idx <= 3'd7;
                r_cnt <= '0;
            end else begin
                case (r_state)
                    ST_SCAN: begin
                        r_x   <= w_attr[ATTR_X_LSB +: 8];
                        r_pat <= w_attr[ATTR_PAT_LSB +: 4];
                        r_row <= w_diff[3:0];
                        r_cnt <= '0;
                        if (!w_hit && !w_last_idx) r_idx <= r_idx - 3'd1;
                    end
                    ST_FETCH: begin
                        r_cnt <= r_cnt + 5'd1;
                        if (w_last_col && !w_last_idx) r_idx <= r_idx - 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPRITE_FLIP_EN
    logic r_hflip, r_vflip;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hflip <= 1'b0;
            r_vflip <= 1'b0;
        end else if (r_state == ST_SCAN && !line_start) begin
            r_hflip <= w_attr[ATTR_HFLIP_BIT];
            r_vflip <= w_attr[ATTR_VFLIP_BIT];
        end
    end

    assign w_rowp        = r_row ^ {4{r_vflip}};
    assign w_colp        = r_cnt[3:0] ^ {4{r_hflip}};
    assign w_unused_bits = ^{w_attr[ATTR_RSVD_BIT], mem_rdata[5:4]};
`else
    assign w_rowp        = r_row;
    assign w_colp        = r_cnt[3:0];
    assign w_unused_bits = ^{w_attr[ATTR_VFLIP_BIT], w_attr[ATTR_HFLIP_BIT],
                             w_attr[ATTR_RSVD_BIT], mem_rdata[5:4]};
`endif

    assign mem_raddr = mem_ren ? {r_pat, w_rowp, w_colp} : 12'd0;

    // Destination column uses the unflipped col; bit 8 marks pixels past the right edge.
    assign w_sum    = {1'b0, r_x} + {5'd0, r_wcol};
    assign lb_wen   = r_wr_pend && (mem_rdata[3:0] != TRANSPARENT_IDX) && !w_sum[8];
    assign lb_waddr = r_wr_pend ? w_sum[7:0] : 8'd0;
    assign lb_wdata = r_wr_pend ? mem_rdata[3:0] : 4'd0;

endmodule
